// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops finish in one clock; MUL/DIV/DIVU iterate one bit per clock.
// Optional feature macro ALU_MULDIV_EN enables the iterative multiply/divide datapath.
module alu_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         alu_op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   c,
  output logic [WIDTH-1:0]   c_hi,
  output logic               zero,
  output logic               carry,
  output logic               negative,
  output logic               overflow
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOR  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_LUI  = 4'd12;
  localparam logic [3:0] OP_MUL  = 4'd13;
  localparam logic [3:0] OP_DIV  = 4'd14;
  localparam logic [3:0] OP_DIVU = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH:0]   add_s;
  logic [WIDTH:0]   sub_s;
  logic [WIDTH-1:0] sc_c_s;
  logic [WIDTH-1:0] sc_hi_s;
  logic             sc_carry_s;
  logic             sc_ov_s;
  logic             is_md_s;

  // Single-cycle result computed straight from the request operands.
  always_comb begin
    add_s      = {1'b0, a} + {1'b0, b};
    sub_s      = {1'b0, a} - {1'b0, b};
    sc_c_s     = a;
    sc_hi_s    = {WIDTH{1'b0}};
    sc_carry_s = 1'b0;
    sc_ov_s    = 1'b0;
    case (alu_op)
      OP_NOP:  sc_c_s = a;
      OP_ADD: begin
        sc_c_s     = add_s[WIDTH-1:0];
        sc_carry_s = add_s[WIDTH];
        sc_ov_s    = (a[WIDTH-1] == b[WIDTH-1]) && (add_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_c_s     = sub_s[WIDTH-1:0];
        sc_carry_s = sub_s[WIDTH];
        sc_ov_s    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_s[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_c_s = a & b;
      OP_OR:   sc_c_s = a | b;
      OP_XOR:  sc_c_s = a ^ b;
      OP_NOR:  sc_c_s = ~(a | b);
      OP_SLT:  sc_c_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_c_s = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  sc_c_s = a << shamt;
      OP_SRL:  sc_c_s = a >> shamt;
      OP_SRA:  sc_c_s = $signed(a) >>> shamt;
      OP_LUI:  sc_c_s = {b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
`ifndef ALU_MULDIV_EN
      OP_MUL, OP_DIV, OP_DIVU: begin
        sc_c_s  = {WIDTH{1'b0}};
        sc_ov_s = 1'b1;
      end
`endif
      default: sc_c_s = a;
    endcase
  end

`ifdef ALU_MULDIV_EN
  // Operands are stored as magnitudes; signs are reapplied after the last step.
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
    mag = (is_signed && v[WIDTH-1]) ? ({WIDTH{1'b0}} - v) : v;
  endfunction

  logic [WIDTH-1:0]   hi_r, lo_r, mcand_r, a_r, b_r;
  logic [3:0]         op_r;
  logic [SHAMT_W-1:0] cnt_r;
  logic [WIDTH:0]     mul_sum_s, rem_sh_s;
  logic               div_ge_s;
  logic [WIDTH-1:0]   hi_nx_s, lo_nx_s, md_c_s, md_hi_s;
  logic [2*WIDTH-1:0] prod_s;
  logic               md_ov_s;

  assign is_md_s = (alu_op == OP_MUL) || (alu_op == OP_DIV) || (alu_op == OP_DIVU);

  // One shift-add / restoring-divide step and the signed fix-up of the final step.
  always_comb begin
    mul_sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    rem_sh_s  = {hi_r, lo_r[WIDTH-1]};
    div_ge_s  = (rem_sh_s >= {1'b0, mcand_r});
    if (op_r == OP_MUL) begin
      hi_nx_s = mul_sum_s[WIDTH:1];
      lo_nx_s = {mul_sum_s[0], lo_r[WIDTH-1:1]};
    end else begin
      hi_nx_s = div_ge_s ? (rem_sh_s[WIDTH-1:0] - mcand_r) : rem_sh_s[WIDTH-1:0];
      lo_nx_s = {lo_r[WIDTH-2:0], div_ge_s};
    end
    prod_s  = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) ? ({(2*WIDTH){1'b0}} - {hi_nx_s, lo_nx_s})
                                           : {hi_nx_s, lo_nx_s};
    md_c_s  = lo_nx_s;
    md_hi_s = hi_nx_s;
    md_ov_s = 1'b0;
    if (op_r == OP_MUL) begin
      md_c_s  = prod_s[WIDTH-1:0];
      md_hi_s = prod_s[2*WIDTH-1:WIDTH];
      md_ov_s = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
    end else if (b_r == {WIDTH{1'b0}}) begin
      md_c_s  = {WIDTH{1'b1}};
      md_hi_s = a_r;
      md_ov_s = 1'b1;
    end else if (op_r == OP_DIV) begin
      md_c_s  = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) ? ({WIDTH{1'b0}} - lo_nx_s) : lo_nx_s;
      md_hi_s = a_r[WIDTH-1] ? ({WIDTH{1'b0}} - hi_nx_s) : hi_nx_s;
      md_ov_s = (a_r == {1'b1, {(WIDTH-1){1'b0}}}) && (b_r == {WIDTH{1'b1}});
    end else begin
      md_c_s  = lo_nx_s;
      md_hi_s = hi_nx_s;
    end
  end
`else
  assign is_md_s = 1'b0;
`endif

  // Control FSM: registered handshakes, result/flag registers and the iterative working state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      c         <= {WIDTH{1'b0}};
      c_hi      <= {WIDTH{1'b0}};
      zero      <= 1'b0;
      carry     <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
`ifdef ALU_MULDIV_EN
      hi_r      <= {WIDTH{1'b0}};
      lo_r      <= {WIDTH{1'b0}};
      mcand_r   <= {WIDTH{1'b0}};
      a_r       <= {WIDTH{1'b0}};
      b_r       <= {WIDTH{1'b0}};
      op_r      <= 4'd0;
      cnt_r     <= {SHAMT_W{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_md_s) begin
              state_r <= BUSY;
`ifdef ALU_MULDIV_EN
              op_r    <= alu_op;
              a_r     <= a;
              b_r     <= b;
              cnt_r   <= {SHAMT_W{1'b0}};
              hi_r    <= {WIDTH{1'b0}};
              mcand_r <= (alu_op == OP_MUL) ? mag(a, 1'b1) : mag(b, alu_op == OP_DIV);
              lo_r    <= (alu_op == OP_MUL) ? mag(b, 1'b1) : mag(a, alu_op == OP_DIV);
`endif
            end else begin
              state_r   <= DONE;
              out_valid <= 1'b1;
              c         <= sc_c_s;
              c_hi      <= sc_hi_s;
              zero      <= (sc_c_s == {WIDTH{1'b0}});
              negative  <= sc_c_s[WIDTH-1];
              carry     <= sc_carry_s;
              overflow  <= sc_ov_s;
            end
          end
        end
        BUSY: begin
`ifdef ALU_MULDIV_EN
          hi_r  <= hi_nx_s;
          lo_r  <= lo_nx_s;
          cnt_r <= cnt_r + SHAMT_W'(1);
          if (cnt_r == SHAMT_W'(WIDTH-1)) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
            c         <= md_c_s;
            c_hi      <= md_hi_s;
            zero      <= (md_c_s == {WIDTH{1'b0}});
            negative  <= md_c_s[WIDTH-1];
            carry     <= 1'b0;
            overflow  <= md_ov_s;
          end
`else
          state_r  <= IDLE;
          in_ready <= 1'b1;
`endif
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed vector table, random ops against a
// behavioural model, plus hold and mid-operation reset sequences. Honours ALU_MULDIV_EN.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_op = 4'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [4:0]  shamt = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] c, c_hi;
  logic        zero, carry, negative, overflow;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] c;
    logic [31:0] hi;
    logic [3:0]  fl;     // {zero, carry, negative, overflow}
    logic        chk_cy;
    int          lat;
  } vec_t;

  vec_t vt[$];
  logic [31:0] edge_vals [0:5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h2};

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .a(a), .b(b), .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .c_hi(c_hi), .zero(zero), .carry(carry), .negative(negative), .overflow(overflow)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] ia, ib, input logic [4:0] sh,
                         input logic [31:0] ec, eh, input logic [3:0] ef, input logic cy, input int lat);
    vec_t v;
    v.op = op; v.a = ia; v.b = ib; v.sh = sh; v.c = ec; v.hi = eh; v.fl = ef; v.chk_cy = cy; v.lat = lat;
    vt.push_back(v);
  endtask

  // Reference model from the arithmetic definitions of each opcode.
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] ia, ib, input logic [4:0] sh);
    vec_t r;
    longint sa, sb, ua, ub, s, maxs, mins;
    logic [63:0] p;
    logic cy, ov;
    logic [31:0] cc, hh;
    maxs = 64'sd2147483647; mins = -64'sd2147483648;
    sa = longint'($signed(ia)); sb = longint'($signed(ib));
    ua = longint'(ia); ub = longint'(ib);
    cc = ia; hh = 32'h0; cy = 1'b0; ov = 1'b0;
    r.lat = 1; r.chk_cy = 1'b1;
    case (op)
      4'd1: begin s = ua + ub; cc = s[31:0]; cy = s[32]; ov = (sa + sb > maxs) || (sa + sb < mins); end
      4'd2: begin s = sa - sb; cc = s[31:0]; cy = (ua < ub); ov = (s > maxs) || (s < mins); end
      4'd3: cc = ia & ib;
      4'd4: cc = ia | ib;
      4'd5: cc = ia ^ ib;
      4'd6: cc = ~(ia | ib);
      4'd7: cc = (sa < sb) ? 32'd1 : 32'd0;
      4'd8: cc = (ua < ub) ? 32'd1 : 32'd0;
      4'd9: cc = ia << sh;
      4'd10: cc = ia >> sh;
      4'd11: begin s = sa >>> sh; cc = s[31:0]; end
      4'd12: cc = ib << 16;
`ifdef ALU_MULDIV_EN
      4'd13: begin
        s = sa * sb; p = s; cc = p[31:0]; hh = p[63:32];
        ov = (s > maxs) || (s < mins); r.lat = 33; r.chk_cy = 1'b0;
      end
      4'd14: begin
        r.lat = 33; r.chk_cy = 1'b0;
        if (ib == 32'd0) begin cc = 32'hFFFFFFFF; hh = ia; ov = 1'b1; end
        else if (sa == mins && sb == -64'sd1) begin cc = 32'h80000000; hh = 32'd0; ov = 1'b1; end
        else begin s = sa / sb; cc = s[31:0]; s = sa % sb; hh = s[31:0]; end
      end
      4'd15: begin
        r.lat = 33; r.chk_cy = 1'b0;
        if (ib == 32'd0) begin cc = 32'hFFFFFFFF; hh = ia; ov = 1'b1; end
        else begin s = ua / ub; cc = s[31:0]; s = ua % ub; hh = s[31:0]; end
      end
`else
      4'd13, 4'd14, 4'd15: begin cc = 32'd0; hh = 32'd0; ov = 1'b1; r.chk_cy = 1'b0; end
`endif
      default: cc = ia;
    endcase
    r.op = op; r.a = ia; r.b = ib; r.sh = sh; r.c = cc; r.hi = hh;
    r.fl = {(cc == 32'd0), cy, cc[31], ov};
    return r;
  endfunction

  function automatic logic [31:0] pick();
    int k;
    k = $urandom_range(0, 3);
    if (k == 0) return edge_vals[$urandom_range(0, 5)];
    else if (k == 1) return 32'($urandom_range(0, 40));
    else return $urandom();
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [31:0] ia, ib, input logic [4:0] sh,
                        output logic [31:0] gc, gh, output logic [3:0] gf, output int gl,
                        output logic rdy_seen);
    int w;
    w = 0;
    while (!in_ready && w < 100) begin @(posedge clk); #1; w++; end
    if (!in_ready) check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    alu_op = op; a = ia; b = ib; shamt = sh; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    gl = 1;
    rdy_seen = in_ready;
    while (!out_valid && gl < 100) begin
      @(posedge clk); #1;
      gl++;
      if (in_ready) rdy_seen = 1'b1;
    end
    gc = c; gh = c_hi; gf = {zero, carry, negative, overflow};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic check_op(input string tag, input vec_t e, input logic [31:0] gc, gh,
                          input logic [3:0] gf, input int gl, input logic rs);
    logic [3:0] m;
    m = e.chk_cy ? 4'hF : 4'hB;
    check({tag, "_c"}, gc, e.c);
    check({tag, "_hi"}, gh, e.hi);
    check({tag, "_flags"}, gf & m, e.fl & m);
    check({tag, "_latency"}, gl, e.lat);
    check({tag, "_in_ready_low"}, rs, 1'b0);
  endtask

  initial begin
    logic [31:0] gc, gh;
    logic [3:0]  gf;
    int          gl;
    logic        rs;
    vec_t        m;
    logic [3:0]  rop;

    add_vec(4'd1,  32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, 32'h0, 4'h3, 1'b1, 1);
    add_vec(4'd2,  32'h0, 32'h1, 5'd0, 32'hFFFFFFFF, 32'h0, 4'h6, 1'b1, 1);
    add_vec(4'd11, 32'h80000000, 32'h0, 5'd4, 32'hF8000000, 32'h0, 4'h2, 1'b1, 1);
    add_vec(4'd1,  32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 32'h0, 4'hC, 1'b1, 1);
    add_vec(4'd9,  32'h12345678, 32'h0, 5'd0, 32'h12345678, 32'h0, 4'h0, 1'b1, 1);
    add_vec(4'd10, 32'h80000000, 32'h0, 5'd31, 32'h1, 32'h0, 4'h0, 1'b1, 1);
    add_vec(4'd12, 32'h0, 32'h1234ABCD, 5'd0, 32'hABCD0000, 32'h0, 4'h2, 1'b1, 1);
    add_vec(4'd7,  32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, 32'h0, 4'h0, 1'b1, 1);
    add_vec(4'd8,  32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, 32'h0, 4'h8, 1'b1, 1);
    add_vec(4'd6,  32'h0, 32'h0, 5'd0, 32'hFFFFFFFF, 32'h0, 4'h2, 1'b1, 1);
    add_vec(4'd3,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd0, 32'h00F000F0, 32'h0, 4'h0, 1'b1, 1);
    add_vec(4'd0,  32'h80000001, 32'h5, 5'd0, 32'h80000001, 32'h0, 4'h2, 1'b1, 1);
`ifdef ALU_MULDIV_EN
    add_vec(4'd13, 32'hFFFFFFFD, 32'h7, 5'd0, 32'hFFFFFFEB, 32'hFFFFFFFF, 4'h2, 1'b0, 33);
    add_vec(4'd14, 32'hFFFFFFF9, 32'h2, 5'd0, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'h2, 1'b0, 33);
    add_vec(4'd15, 32'h5, 32'h0, 5'd0, 32'hFFFFFFFF, 32'h5, 4'h3, 1'b0, 33);
    add_vec(4'd14, 32'h80000000, 32'hFFFFFFFF, 5'd0, 32'h80000000, 32'h0, 4'h3, 1'b0, 33);
    add_vec(4'd13, 32'h80000000, 32'h80000000, 5'd0, 32'h0, 32'h40000000, 4'h9, 1'b0, 33);
`else
    add_vec(4'd13, 32'hFFFFFFFD, 32'h7, 5'd0, 32'h0, 32'h0, 4'h9, 1'b0, 1);
    add_vec(4'd14, 32'hFFFFFFF9, 32'h2, 5'd0, 32'h0, 32'h0, 4'h9, 1'b0, 1);
    add_vec(4'd15, 32'h5, 32'h0, 5'd0, 32'h0, 32'h0, 4'h9, 1'b0, 1);
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_handshake", {in_ready, out_valid}, 2'b10);
    check("reset_result", {c_hi, c}, 64'd0);
    check("reset_flags", {zero, carry, negative, overflow}, 4'h0);
    rstn = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].sh, gc, gh, gf, gl, rs);
      check_op($sformatf("vec%0d", i), vt[i], gc, gh, gf, gl, rs);
    end

    for (int i = 0; i < 250; i++) begin
      rop = 4'($urandom_range(0, 15));
      m = model(rop, pick(), pick(), 5'($urandom_range(0, 31)));
      run_op(m.op, m.a, m.b, m.sh, gc, gh, gf, gl, rs);
      check_op($sformatf("rand%0d_op%0d", i, m.op), m, gc, gh, gf, gl, rs);
    end

    // Result held under back-pressure; requests ignored while not ready
    m = model(4'd5, 32'hDEADBEEF, 32'hDEADBEEF, 5'd0);
    alu_op = 4'd5; a = 32'hDEADBEEF; b = 32'hDEADBEEF; in_valid = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      alu_op = 4'd1; a = 32'd7; b = 32'd9; in_valid = k[0];
      check($sformatf("hold%0d", k), {out_valid, in_ready, zero, carry, negative, overflow, c},
            {1'b1, 1'b0, m.fl, m.c});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("hold_release", {out_valid, in_ready}, 2'b01);

    // Asynchronous reset in the middle of a divide
    alu_op = 4'd14; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midreset_handshake", {in_ready, out_valid}, 2'b10);
    check("midreset_result", {c_hi, c}, 64'd0);
    check("midreset_flags", {zero, carry, negative, overflow}, 4'h0);
    #3 rstn = 1'b1;
    @(posedge clk); #1;
    m = model(4'd1, 32'd2, 32'd3, 5'd0);
    run_op(4'd1, 32'd2, 32'd3, 5'd0, gc, gh, gf, gl, rs);
    check("after_reset_add_c", gc, 32'd5);
    check_op("after_reset_add", m, gc, gh, gf, gl, rs);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
